// File: rtl/segre_mem_responder.sv
// segre_mem_responder: memory-side responder for the segre_core load/store port.
// Word-organised little-endian RAM with a fixed access latency of LATENCY cycles
// from the request being sampled in IDLE to the one-cycle mem_ready_o pulse.
// Optional feature: define SEGRE_MEM_MISALIGN_CHECK_EN to add err_o and make
// misaligned accesses fail (no RAM update, read data 0).
module segre_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 2
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  rd_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0]            data_type_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
  output logic                  err_o,
`endif
  output logic                  mem_ready_o
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              type_q;
  logic [31:0]             wdata_q;
  logic                    wr_q;
  logic [31:0]             data_q;
  logic                    ready_q;

  logic [31:0]             ram [DEPTH_WORDS];

  // Byte offset of the lowest selected lane; low bits a size cannot use are dropped.
  function automatic logic [1:0] lane_off(input logic [1:0] a, input logic [1:0] t);
    case (t)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] t, input logic [1:0] off);
    case (t)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misal(input logic [1:0] a, input logic [1:0] t);
    return (t == 2'b01 && a[0]) || (t[1] && a != 2'b00);
  endfunction

  // The access that is about to respond: live inputs when LATENCY==1 jumps
  // straight from IDLE to RESP, latched values otherwise.
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [1:0]            cur_type;
  logic                  cur_wr;
  logic                  go_resp;
  logic [1:0]            rd_off;
  logic [31:0]           rd_word;
  logic [31:0]           rdata;
  logic                  cur_mis;

  // Select the responding access and build right-aligned, zero-extended read data.
  always_comb begin
    cur_addr = addr_q;
    cur_type = type_q;
    cur_wr   = wr_q;
    if (state_q == IDLE) begin
      cur_addr = addr_i;
      cur_type = data_type_i;
      cur_wr   = wr_i;
    end
    go_resp = (state_q == IDLE && (rd_i || wr_i) && LATENCY == 1) ||
              (state_q == BUSY && cnt_q == 4'd1);
    rd_off  = lane_off(cur_addr[1:0], cur_type);
    rd_word = ram[cur_addr[IW+1:2]] >> {rd_off, 3'b000};
    case (cur_type)
      2'b00:   rdata = {24'h0, rd_word[7:0]};
      2'b01:   rdata = {16'h0, rd_word[15:0]};
      default: rdata = rd_word;
    endcase
    cur_mis = misal(cur_addr[1:0], cur_type);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
    if (cur_mis) rdata = 32'h0;
`endif
  end

  // Control FSM with registered ready/data (and error) outputs.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      type_q  <= 2'b00;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      data_q  <= 32'h0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= go_resp;
      if (go_resp && !cur_wr) data_q <= rdata;
      case (state_q)
        IDLE: if (rd_i || wr_i) begin
          addr_q  <= addr_i;
          type_q  <= data_type_i;
          wdata_q <= data_i;
          wr_q    <= wr_i;
          if (LATENCY == 1) state_q <= RESP;
          else begin
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
  logic err_q;
  // Error flag pulses alongside ready for a misaligned access.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) err_q <= 1'b0;
    else        err_q <= go_resp && cur_mis;
  end
  assign err_o = err_q;
  wire wr_ok = !misal(addr_q[1:0], type_q);
`else
  wire wr_ok = 1'b1;
`endif

  logic [1:0]  wr_off;
  logic [3:0]  wr_be;
  logic [31:0] wr_sh;
  assign wr_off = lane_off(addr_q[1:0], type_q);
  assign wr_be  = lane_be(type_q, wr_off);
  assign wr_sh  = wdata_q << {wr_off, 3'b000};

  // Byte-enabled RAM write at the end of the RESP cycle; reset in RESP aborts it.
  always_ff @(posedge clk_i) begin
    if (state_q == RESP && wr_q && wr_ok) begin
      for (int l = 0; l < 4; l++)
        if (wr_be[l]) ram[addr_q[IW+1:2]][8*l +: 8] <= wr_sh[8*l +: 8];
    end
  end

  assign data_o      = data_q;
  assign mem_ready_o = ready_q;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{addr_q[ADDR_WIDTH-1:IW+2], addr_i[ADDR_WIDTH-1:IW+2], cur_mis};

endmodule

// File: tb/tb_segre_mem_responder.sv
// Bench for segre_mem_responder: byte-level memory model plus a per-cycle
// compare process for mem_ready_o / data_o (/ err_o), directed literal cases
// and a randomized traffic phase.
module tb_segre_mem_responder;
  localparam int DEPTH = 16384;
  localparam int LAT   = 2;
  localparam int SPAN  = 4 * DEPTH;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        rd_i, wr_i;
  logic [31:0] addr_i;
  logic [1:0]  data_type_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        mem_ready_o;
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
  logic        err_o;
`endif

  segre_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .rd_i(rd_i), .wr_i(wr_i), .addr_i(addr_i),
    .data_type_i(data_type_i), .data_i(data_i), .data_o(data_o),
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
    .err_o(err_o),
`endif
    .mem_ready_o(mem_ready_o));

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- byte-addressed reference memory ----
  bit [7:0] mb [int];
  function automatic bit is_mis(input bit [31:0] a, input bit [1:0] t);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
    return (t == 1 && a[0]) || (t >= 2 && a[1:0] != 0);
`else
    return 0;
`endif
  endfunction
  function automatic int nbytes(input bit [1:0] t);
    return (t == 0) ? 1 : (t == 1) ? 2 : 4;
  endfunction
  function automatic int base_of(input bit [31:0] a, input bit [1:0] t);
    int b = (t == 0) ? int'(a) : (t == 1) ? int'(a & ~32'd1) : int'(a & ~32'd3);
    return b & (SPAN - 1);
  endfunction
  function automatic void m_write(input bit [31:0] a, input bit [1:0] t, input bit [31:0] d);
    if (is_mis(a, t)) return;
    for (int i = 0; i < nbytes(t); i++) mb[(base_of(a, t) + i) & (SPAN - 1)] = d[8*i +: 8];
  endfunction
  function automatic bit [31:0] m_read(input bit [31:0] a, input bit [1:0] t);
    bit [31:0] r = 0;
    int k;
    if (is_mis(a, t)) return 0;
    for (int i = 0; i < nbytes(t); i++) begin
      k = (base_of(a, t) + i) & (SPAN - 1);
      r[8*i +: 8] = mb.exists(k) ? mb[k] : 8'h00;
    end
    return r;
  endfunction

  // ---- expectations shared with the compare process ----
  int        pend_cyc = -1;
  bit        pend_rd;
  bit [31:0] pend_data;
  bit        pend_err;
  bit [31:0] exp_dout = 0;
  bit        exp_err;

  // Compare process: every cycle out of reset, ready/data(/err) must match the model.
  always @(negedge clk_i) begin
    if (rsn_i === 1'b1) begin
      exp_err = 0;
      if (cyc == pend_cyc) begin
        if (pend_rd) exp_dout = pend_data;
        exp_err  = pend_err;
        chk("ready_pulse", {31'h0, mem_ready_o}, 32'h1);
        pend_cyc = -1;
      end else begin
        chk("ready_idle", {31'h0, mem_ready_o}, 32'h0);
      end
      chk("data_o", data_o, exp_dout);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
      chk("err_o", {31'h0, err_o}, {31'h0, exp_err});
`endif
    end
  end

  // One transaction: present at a negedge, scramble non-sampled inputs while
  // waiting, drop the request on the ready pulse.
  task automatic do_op(input bit wr, input bit rd, input bit [31:0] a, input bit [1:0] t,
                       input bit [31:0] d, output bit [31:0] got);
    int n;
    @(negedge clk_i);
    rd_i = rd; wr_i = wr; addr_i = a; data_type_i = t; data_i = d;
    pend_rd   = !wr;
    pend_data = wr ? 32'h0 : m_read(a, t);
    pend_err  = is_mis(a, t);
    pend_cyc  = cyc + LAT;
    if (wr) m_write(a, t, d);
    got = 0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (mem_ready_o !== 1'b1) begin
        addr_i = $urandom; data_i = $urandom; data_type_i = 2'($urandom);
      end
    end while (mem_ready_o !== 1'b1 && n < 20);
    if (n >= 20) chk("ready_timeout", 32'h0, 32'h1);
    got = data_o;
    rd_i = 0; wr_i = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_i);
    rsn_i = 0; rd_i = 0; wr_i = 0;
    pend_cyc = -1; exp_dout = 0;
    #1;
    chk("rst_ready", {31'h0, mem_ready_o}, 32'h0);
    chk("rst_data", data_o, 32'h0);
    repeat (cycles) @(negedge clk_i);
    rsn_i = 1;
  endtask

  bit [31:0] got;
  bit [31:0] pool [8] = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h200, 32'h204, 32'hFFFC};

  initial begin
    rsn_i = 0; rd_i = 0; wr_i = 0; addr_i = 0; data_type_i = 0; data_i = 0;
    do_reset(3);
    // Preload, then reset and read word 0 (ready expected exactly at t+LAT).
    do_op(1, 0, 32'h0,  2'b10, 32'h11223344, got);
    do_op(1, 0, 32'h40, 2'b10, 32'h0BADF00D, got);
    do_reset(2);
    do_op(0, 1, 32'h0, 2'b10, 0, got);
    chk("lit_preload_w0", got, 32'h11223344);
    // Byte merge into a word.
    do_op(1, 0, 32'h100, 2'b10, 32'hDEADBEEF, got);
    do_op(1, 0, 32'h102, 2'b00, 32'hFFFFFF55, got);
    do_op(0, 1, 32'h100, 2'b10, 0, got);
    chk("lit_byte_merge", got, 32'hDE55BEEF);
    // Half write / half and byte read-back.
    do_op(1, 0, 32'h206, 2'b01, 32'h1234A5A5, got);
    do_op(0, 1, 32'h206, 2'b01, 0, got);
    chk("lit_half_rd", got, 32'h0000A5A5);
    do_op(0, 1, 32'h207, 2'b00, 0, got);
    chk("lit_byte_rd", got, 32'h000000A5);
    // Reset in BUSY of a write to 0x40: dropped, RAM untouched.
    @(negedge clk_i);
    wr_i = 1; addr_i = 32'h40; data_type_i = 2'b10; data_i = 32'hFFFFFFFF;
    @(negedge clk_i);
    rsn_i = 0; wr_i = 0; pend_cyc = -1; exp_dout = 0;
    repeat (2) begin
      @(negedge clk_i);
      chk("busy_rst_ready", {31'h0, mem_ready_o}, 32'h0);
    end
    rsn_i = 1;
    repeat (3) @(negedge clk_i);
    do_op(0, 1, 32'h40, 2'b10, 0, got);
    chk("lit_rst_drop", got, 32'h0BADF00D);
    // Address wrap.
    do_op(1, 0, SPAN + 8, 2'b10, 32'h12345678, got);
    do_op(0, 1, 32'h8, 2'b10, 0, got);
    chk("lit_wrap", got, 32'h12345678);
    // Both rd and wr: executes as a write.
    do_op(1, 1, 32'h104, 2'b10, 32'h5A5A0F0F, got);
    do_op(0, 1, 32'h104, 2'b10, 0, got);
    chk("lit_rdwr_is_wr", got, 32'h5A5A0F0F);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
    do_op(1, 0, 32'h3, 2'b10, 32'hCAFEF00D, got);
    do_op(0, 1, 32'h0, 2'b10, 0, got);
    chk("lit_mis_nowrite", got, 32'h11223344);
`endif
    // Randomized traffic over a small pool of words with wrap aliases.
    foreach (pool[i]) do_op(1, 0, pool[i], 2'b10, $urandom, got);
    for (int k = 0; k < 300; k++) begin
      bit [31:0] a;
      bit w, r;
      a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 3)) << 16);
      w = $urandom_range(0, 1);
      r = !w || ($urandom_range(0, 3) == 0);
      do_op(w, r, a, 2'($urandom), $urandom, got);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
